// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit and the memory interface behind it:
// access word types, LSU FSM states and per-type access sizes.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        WT_BYTE     = 2'b00,
        WT_HALFWORD = 2'b01,
        WT_WORD     = 2'b10,
        WT_ILLEGAL  = 2'b11
    } word_type_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_LD = 3'd2,
        WAIT_ST = 3'd3,
        RESP    = 3'd4
    } lsu_state_e;

    localparam int unsigned SIZE_BYTE     = 1;
    localparam int unsigned SIZE_HALFWORD = 2;
    localparam int unsigned SIZE_WORD     = 4;

    // Offset of the last byte touched by an access, relative to its start address.
    function automatic logic [1:0] end_offset(input logic [1:0] word_type);
        case (word_type)
            WT_HALFWORD: return 2'(SIZE_HALFWORD - 1);
            WT_WORD:     return 2'(SIZE_WORD - 1);
            default:     return 2'(SIZE_BYTE - 1);
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_req_buffer.sv
// One-entry request buffer with acceptance-time validation: illegal word types and
// accesses running past the top of memory are dropped and flagged with err_pulse_o.
module lsu_req_buffer
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int RD_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_word_type,
    input  logic              req_is_signed,
    input  logic [RD_W-1:0]   req_rd,
    input  logic              pop_i,
    output logic              buf_valid_o,
    output logic              buf_is_store_o,
    output logic [ADDR_W-1:0] buf_address_o,
    output logic [DATA_W-1:0] buf_wdata_o,
    output logic [1:0]        buf_word_type_o,
    output logic              buf_is_signed_o,
    output logic [RD_W-1:0]   buf_rd_o,
    output logic              err_pulse_o
);

    logic              valid_q, valid_d;
    logic              is_store_q, is_store_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        word_type_q, word_type_d;
    logic              is_signed_q, is_signed_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              err_q;

    logic              accept;
    logic              illegal;
    logic [ADDR_W:0]   end_addr;

    assign req_ready = !valid_q;
    assign accept    = req_valid && req_ready;

    // One extra bit so an access straddling the top of memory shows up as a carry.
    assign end_addr = {1'b0, req_address} + {{(ADDR_W - 1){1'b0}}, end_offset(req_word_type)};
    assign illegal  = (req_word_type == WT_ILLEGAL) || end_addr[ADDR_W];

    always_comb begin
        valid_d     = valid_q;
        is_store_d  = is_store_q;
        address_d   = address_q;
        wdata_d     = wdata_q;
        word_type_d = word_type_q;
        is_signed_d = is_signed_q;
        rd_d        = rd_q;
        if (pop_i) begin
            valid_d = 1'b0;
        end
        if (accept && !illegal) begin
            valid_d     = 1'b1;
            is_store_d  = req_is_store;
            address_d   = req_address;
            wdata_d     = req_wdata;
            word_type_d = req_word_type;
            is_signed_d = req_is_signed;
            rd_d        = req_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            is_store_q  <= 1'b0;
            address_q   <= '0;
            wdata_q     <= '0;
            word_type_q <= '0;
            is_signed_q <= 1'b0;
            rd_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            is_store_q  <= is_store_d;
            address_q   <= address_d;
            wdata_q     <= wdata_d;
            word_type_q <= word_type_d;
            is_signed_q <= is_signed_d;
            rd_q        <= rd_d;
            err_q       <= accept && illegal;
        end
    end

    assign buf_valid_o     = valid_q;
    assign buf_is_store_o  = is_store_q;
    assign buf_address_o   = address_q;
    assign buf_wdata_o     = wdata_q;
    assign buf_word_type_o = word_type_q;
    assign buf_is_signed_o = is_signed_q;
    assign buf_rd_o        = rd_q;
    assign err_pulse_o     = err_q;

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: buffers one request, issues it to the memory interface as a strobe
// and returns load data to writeback. Optional watchdog enabled by LSU_TIMEOUT_EN.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W         = 13,
    parameter int DATA_W         = 32,
    parameter int RD_W           = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_word_type,
    input  logic              req_is_signed,
    input  logic [RD_W-1:0]   req_rd,
    output logic [ADDR_W-1:0] mi_address,
    output logic [DATA_W-1:0] mi_data_in,
    output logic              mi_load,
    output logic              mi_store,
    output logic              mi_is_signed,
    output logic [1:0]        mi_word_type,
    input  logic [DATA_W-1:0] mi_data_out,
    input  logic              mi_output_valid,
    input  logic              mi_write_ready,
    input  logic              mi_busy,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              store_done,
    output logic              err,
    output logic              busy
);

    logic              buf_valid;
    logic              buf_is_store;
    logic [ADDR_W-1:0] buf_address;
    logic [DATA_W-1:0] buf_wdata;
    logic [1:0]        buf_word_type;
    logic              buf_is_signed;
    logic [RD_W-1:0]   buf_rd;
    logic              buf_err;

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic [1:0]        word_type_q, word_type_d;
    logic              is_signed_q, is_signed_d;
    logic              is_store_q, is_store_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              store_done_q, store_done_d;

    logic              issue_go;
    logic              waiting;
    logic              timeout_hit;

    lsu_req_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) u_req_buffer (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_is_store    (req_is_store),
        .req_address     (req_address),
        .req_wdata       (req_wdata),
        .req_word_type   (req_word_type),
        .req_is_signed   (req_is_signed),
        .req_rd          (req_rd),
        .pop_i           (issue_go),
        .buf_valid_o     (buf_valid),
        .buf_is_store_o  (buf_is_store),
        .buf_address_o   (buf_address),
        .buf_wdata_o     (buf_wdata),
        .buf_word_type_o (buf_word_type),
        .buf_is_signed_o (buf_is_signed),
        .buf_rd_o        (buf_rd),
        .err_pulse_o     (buf_err)
    );

    assign issue_go = (state_q == IDLE) && buf_valid && !mi_busy;
    assign waiting  = (state_q == WAIT_LD) || (state_q == WAIT_ST);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ISSUE) begin
            tmo_cnt_d = '0;
        end else if (waiting) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // The limit is reached in the cycle the count would hit TIMEOUT_CYCLES; abandoning wins over a late completion.
    assign timeout_hit = waiting && (tmo_cnt_q == LAST_COUNT);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        data_in_d    = data_in_q;
        word_type_d  = word_type_q;
        is_signed_d  = is_signed_q;
        is_store_d   = is_store_q;
        rd_d         = rd_q;
        wb_data_d    = wb_data_q;
        store_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue_go) begin
                    address_d   = buf_address;
                    data_in_d   = buf_wdata;
                    word_type_d = buf_word_type;
                    is_signed_d = buf_is_signed;
                    is_store_d  = buf_is_store;
                    rd_d        = buf_rd;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = is_store_q ? WAIT_ST : WAIT_LD;
            end
            WAIT_LD: begin
                if (timeout_hit) begin
                    state_d = IDLE;
                end else if (mi_output_valid) begin
                    wb_data_d = mi_data_out;
                    state_d   = RESP;
                end
            end
            WAIT_ST: begin
                if (timeout_hit) begin
                    state_d = IDLE;
                end else if (mi_write_ready) begin
                    store_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            RESP: begin
                if (wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            address_q    <= '0;
            data_in_q    <= '0;
            word_type_q  <= '0;
            is_signed_q  <= 1'b0;
            is_store_q   <= 1'b0;
            rd_q         <= '0;
            wb_data_q    <= '0;
            store_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            data_in_q    <= data_in_d;
            word_type_q  <= word_type_d;
            is_signed_q  <= is_signed_d;
            is_store_q   <= is_store_d;
            rd_q         <= rd_d;
            wb_data_q    <= wb_data_d;
            store_done_q <= store_done_d;
        end
    end

    assign mi_address   = address_q;
    assign mi_data_in   = data_in_q;
    assign mi_word_type = word_type_q;
    assign mi_is_signed = is_signed_q;
    assign mi_load      = (state_q == ISSUE) && !is_store_q;
    assign mi_store     = (state_q == ISSUE) && is_store_q;

    assign wb_valid   = (state_q == RESP);
    assign wb_data    = wb_data_q;
    assign wb_rd      = rd_q;
    assign store_done = store_done_q;
    assign err        = buf_err || timeout_hit;
    assign busy       = buf_valid || (state_q != IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios followed by random
// requests checked against a transaction-level model of the expected accesses.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int ADDR_W     = 13;
    localparam int DATA_W     = 32;
    localparam int RD_W       = 4;
    localparam int TB_TIMEOUT = 8;
    localparam int MEM_TOP    = (1 << ADDR_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [ADDR_W-1:0] req_address;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_word_type;
    logic              req_is_signed;
    logic [RD_W-1:0]   req_rd;
    logic [ADDR_W-1:0] mi_address;
    logic [DATA_W-1:0] mi_data_in;
    logic              mi_load;
    logic              mi_store;
    logic              mi_is_signed;
    logic [1:0]        mi_word_type;
    logic [DATA_W-1:0] mi_data_out;
    logic              mi_output_valid;
    logic              mi_write_ready;
    logic              mi_busy;
    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [RD_W-1:0]   wb_rd;
    logic              store_done;
    logic              err;
    logic              busy;

    int errorCount = 0;
    int checkCount = 0;

    typedef struct {
        bit                isStore;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [1:0]        wt;
        bit                sgn;
        logic [RD_W-1:0]   rd;
    } req_t;

    load_store_unit #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .RD_W           (RD_W),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_is_store    (req_is_store),
        .req_address     (req_address),
        .req_wdata       (req_wdata),
        .req_word_type   (req_word_type),
        .req_is_signed   (req_is_signed),
        .req_rd          (req_rd),
        .mi_address      (mi_address),
        .mi_data_in      (mi_data_in),
        .mi_load         (mi_load),
        .mi_store        (mi_store),
        .mi_is_signed    (mi_is_signed),
        .mi_word_type    (mi_word_type),
        .mi_data_out     (mi_data_out),
        .mi_output_valid (mi_output_valid),
        .mi_write_ready  (mi_write_ready),
        .mi_busy         (mi_busy),
        .wb_valid        (wb_valid),
        .wb_ready        (wb_ready),
        .wb_data         (wb_data),
        .wb_rd           (wb_rd),
        .store_done      (store_done),
        .err             (err),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; the execute-stage driver drops req_valid once the handshake completes.
    task automatic tick();
        bit acc;
        acc = req_valid && req_ready;
        @(posedge clk);
        #1;
        if (acc) req_valid = 1'b0;
    endtask

    task automatic applyStimulus(input req_t r);
        req_is_store  = r.isStore;
        req_address   = r.addr;
        req_wdata     = r.wdata;
        req_word_type = r.wt;
        req_is_signed = r.sgn;
        req_rd        = r.rd;
        req_valid     = 1'b1;
    endtask

    function automatic int accessSize(input logic [1:0] wt);
        case (wt)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit isLegal(input req_t r);
        return (r.wt != 2'b11) && (int'(r.addr) + accessSize(r.wt) - 1 <= MEM_TOP);
    endfunction

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_reqReady"}, req_ready, 1);
        checkOutput({tag, "_miFields"}, {mi_address, mi_data_in, mi_word_type, mi_is_signed}, 0);
        checkOutput({tag, "_strobes"}, {mi_load, mi_store}, 0);
        checkOutput({tag, "_wb"}, {wb_valid, wb_data, wb_rd}, 0);
        checkOutput({tag, "_flags"}, {store_done, err, busy}, 0);
    endtask

    task automatic waitStrobe(input req_t r, input int expTicks);
        int n = 0;
        while (!(mi_load || mi_store) && n < 20) begin
            tick();
            n++;
        end
        checkOutput("strobeSeen", mi_load || mi_store, 1);
        if (expTicks >= 0) checkOutput("issueLatency", n, expTicks);
        checkOutput("strobeKind", {mi_load, mi_store}, r.isStore ? 2'b01 : 2'b10);
        checkOutput("issueAddr", mi_address, r.addr);
        checkOutput("issueType", mi_word_type, r.wt);
        checkOutput("issueSigned", mi_is_signed, r.sgn);
        if (r.isStore) checkOutput("issueData", mi_data_in, r.wdata);
    endtask

    task automatic completeAccess(input req_t r, input int latency, input int stall,
                                  input bit spurious, input logic [DATA_W-1:0] rdata);
        if (spurious) begin
            mi_output_valid = 1'b1;
            mi_write_ready  = 1'b1;
            mi_data_out     = ~rdata;
        end
        tick();
        mi_output_valid = 1'b0;
        mi_write_ready  = 1'b0;
        checkOutput("strobeOneCycle", {mi_load, mi_store}, 0);
        for (int i = 1; i <= latency; i++) begin
            checkOutput("holdAddr", mi_address, r.addr);
            checkOutput("holdType", mi_word_type, r.wt);
            checkOutput("holdSigned", mi_is_signed, r.sgn);
            if (r.isStore) checkOutput("holdData", mi_data_in, r.wdata);
            checkOutput("noEarlyDone", {wb_valid, store_done}, 0);
            if (i == latency) begin
                if (r.isStore) begin
                    mi_write_ready = 1'b1;
                end else begin
                    mi_output_valid = 1'b1;
                    mi_data_out     = rdata;
                end
            end
            tick();
        end
        mi_output_valid = 1'b0;
        mi_write_ready  = 1'b0;
        mi_data_out     = $urandom;
        if (r.isStore) begin
            checkOutput("storeDone", store_done, 1);
            checkOutput("noWbOnStore", wb_valid, 0);
            tick();
            checkOutput("storeDonePulse", store_done, 0);
        end else begin
            for (int s = 0; s <= stall; s++) begin
                checkOutput("wbValid", wb_valid, 1);
                checkOutput("wbData", wb_data, rdata);
                checkOutput("wbRd", wb_rd, r.rd);
                if (spurious && s == 0) begin
                    mi_output_valid = 1'b1;
                    mi_data_out     = ~rdata;
                end
                wb_ready = (s == stall);
                tick();
                mi_output_valid = 1'b0;
            end
            wb_ready = 1'b0;
            checkOutput("wbReleased", wb_valid, 0);
        end
    endtask

    task automatic doIllegal(input req_t r);
        checkOutput("illegalReadyBefore", req_ready, 1);
        applyStimulus(r);
        tick();
        checkOutput("errPulse", err, 1);
        checkOutput("illegalReadyAfter", req_ready, 1);
        checkOutput("illegalNotBuffered", busy, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("errOneCycle", err, 0);
            checkOutput("illegalNoStrobe", {mi_load, mi_store}, 0);
        end
    endtask

    initial begin
        req_t r;
        req_t s;
        req_t l;
        logic [DATA_W-1:0] rdata;

        reset = 1'b1;
        req_valid = 1'b0;
        req_is_store = 1'b0;
        req_address = '0;
        req_wdata = '0;
        req_word_type = '0;
        req_is_signed = 1'b0;
        req_rd = '0;
        mi_data_out = '0;
        mi_output_valid = 1'b0;
        mi_write_ready = 1'b0;
        mi_busy = 1'b0;
        wb_ready = 1'b0;

        tick();
        tick();
        checkResetOutputs("rstInit");
        reset = 1'b0;
        tick();
        checkResetOutputs("idleAfterRst");

        $display("[TB] directed load word at 0x0004");
        r = '{isStore: 1'b0, addr: 13'h0004, wdata: 32'h0, wt: WT_WORD, sgn: 1'b0, rd: 4'd5};
        applyStimulus(r);
        tick();
        checkOutput("bufFullReady", req_ready, 0);
        checkOutput("bufFullBusy", busy, 1);
        waitStrobe(r, 1);
        completeAccess(r, 3, 4, 1'b0, 32'hDEADBEEF);

        $display("[TB] directed store halfword at 0x0011");
        r = '{isStore: 1'b1, addr: 13'h0011, wdata: 32'h0000_1234, wt: WT_HALFWORD, sgn: 1'b0, rd: 4'd0};
        applyStimulus(r);
        waitStrobe(r, 2);
        completeAccess(r, 2, 0, 1'b0, '0);

        $display("[TB] directed illegal and boundary requests");
        r = '{isStore: 1'b0, addr: 13'h1FFE, wdata: 32'h0, wt: WT_WORD, sgn: 1'b0, rd: 4'd1};
        doIllegal(r);
        r = '{isStore: 1'b0, addr: 13'h0000, wdata: 32'h0, wt: WT_ILLEGAL, sgn: 1'b0, rd: 4'd1};
        doIllegal(r);
        r = '{isStore: 1'b1, addr: 13'h1FFF, wdata: 32'h0000_ABCD, wt: WT_HALFWORD, sgn: 1'b0, rd: 4'd1};
        doIllegal(r);
        r = '{isStore: 1'b0, addr: 13'h1FFC, wdata: 32'h0, wt: WT_WORD, sgn: 1'b1, rd: 4'd9};
        applyStimulus(r);
        waitStrobe(r, 2);
        completeAccess(r, 1, 0, 1'b0, 32'h1357_9BDF);
        r = '{isStore: 1'b1, addr: 13'h1FFF, wdata: 32'h0000_00A5, wt: WT_BYTE, sgn: 1'b0, rd: 4'd0};
        applyStimulus(r);
        waitStrobe(r, 2);
        completeAccess(r, 1, 0, 1'b0, '0);

        $display("[TB] directed back-to-back store then load behind mi_busy");
        s = '{isStore: 1'b1, addr: 13'h0200, wdata: 32'hCAFE_F00D, wt: WT_WORD, sgn: 1'b0, rd: 4'd0};
        l = '{isStore: 1'b0, addr: 13'h0201, wdata: 32'h0, wt: WT_BYTE, sgn: 1'b1, rd: 4'd12};
        mi_busy = 1'b1;
        applyStimulus(s);
        tick();
        applyStimulus(l);
        for (int i = 0; i < 5; i++) begin
            checkOutput("busyHoldReady", req_ready, 0);
            checkOutput("noStrobeWhileBusy", {mi_load, mi_store}, 0);
            tick();
        end
        mi_busy = 1'b0;
        waitStrobe(s, 1);
        checkOutput("readyAfterIssue", req_ready, 1);
        completeAccess(s, 2, 0, 1'b0, '0);
        waitStrobe(l, 0);
        completeAccess(l, 1, 1, 1'b0, 32'hFFFF_FF80);

        $display("[TB] directed reset during WAIT_LD");
        r = '{isStore: 1'b0, addr: 13'h0100, wdata: 32'h0, wt: WT_WORD, sgn: 1'b0, rd: 4'd3};
        applyStimulus(r);
        waitStrobe(r, 2);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkResetOutputs("rstMidAccess");
        mi_data_out = 32'h0BAD_0BAD;
        mi_output_valid = 1'b1;
        tick();
        mi_output_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("noWbAfterReset", wb_valid, 0);
            checkOutput("idleAfterReset", busy, 0);
            tick();
        end

        $display("[TB] random requests");
        for (int n = 0; n < 40; n++) begin
            r.isStore = 1'($urandom_range(0, 1));
            r.wt      = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            r.addr    = ($urandom_range(0, 1) == 1) ? ADDR_W'(MEM_TOP - $urandom_range(0, 4))
                                                    : ADDR_W'($urandom_range(0, MEM_TOP));
            r.wdata   = $urandom;
            r.sgn     = 1'($urandom_range(0, 1));
            r.rd      = RD_W'($urandom_range(0, 15));
            rdata     = $urandom;
            if (isLegal(r)) begin
                applyStimulus(r);
                waitStrobe(r, 2);
                completeAccess(r, $urandom_range(1, 4), $urandom_range(0, 3),
                               1'($urandom_range(0, 1)), rdata);
            end else begin
                doIllegal(r);
            end
        end

`ifdef LSU_TIMEOUT_EN
        $display("[TB] load with no response times out");
        r = '{isStore: 1'b0, addr: 13'h0040, wdata: 32'h0, wt: WT_WORD, sgn: 1'b0, rd: 4'd7};
        applyStimulus(r);
        waitStrobe(r, 2);
        for (int i = 0; i < TB_TIMEOUT; i++) begin
            checkOutput("noErrBeforeTimeout", err, 0);
            tick();
        end
        checkOutput("timeoutErr", err, 1);
        checkOutput("timeoutNoWb", wb_valid, 0);
        tick();
        checkOutput("timeoutErrPulse", err, 0);
        checkOutput("timeoutIdle", busy, 0);
        mi_output_valid = 1'b1;
        tick();
        mi_output_valid = 1'b0;
        checkOutput("timeoutLateNoWb", wb_valid, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
